// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_pkg
// Purpose  : TileLink-UH opcode constants, responder FSM states, beat helper.
// Revision : 1.0
// ============================================================================
package tl_pkg;

    localparam logic [2:0] A_PUT_FULL      = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] A_ARITH         = 3'd2;
    localparam logic [2:0] A_LOGIC         = 3'd3;
    localparam logic [2:0] A_GET           = 3'd4;
    localparam logic [2:0] A_INTENT        = 3'd5;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Number of 32-bit beats for a transfer of 2^size bytes.
    function automatic logic [13:0] beat_count(input logic [3:0] size);
        if (size < 4'd2) begin
            return 14'd1;
        end
        return 14'd1 << (size - 4'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_imem_ram.sv
`default_nettype none
// ============================================================================
// Module   : tl_imem_ram
// Purpose  : Word-organised synchronous-read RAM with per-byte write enables.
// Revision : 1.0
// ============================================================================
module tl_imem_ram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic              clk,
    input  logic [3:0]        wr_be,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rd_data;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/tl_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_imem_responder
// Purpose  : TileLink-UH slave serving burst Gets and single-beat Puts from
//            an on-chip instruction memory; bad requests get denied replies.
// Revision : 1.0
// ============================================================================
module tl_imem_responder
    import tl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter bit          WRITE_ENABLE = 1'b1
) (
    input  logic        core_clock_i,
    input  logic        core_reset_i,
    input  logic [2:0]  tl_a_opcode,
    input  logic [2:0]  tl_a_param,
    input  logic [3:0]  tl_a_size,
    input  logic [31:0] tl_a_address,
    input  logic [3:0]  tl_a_mask,
    input  logic [31:0] tl_a_data,
    input  logic        tl_a_corrupt,
    input  logic        tl_a_valid,
    output logic        tl_a_ready,
    output logic [2:0]  tl_d_opcode,
    output logic [1:0]  tl_d_param,
    output logic [3:0]  tl_d_size,
    output logic        tl_d_denied,
    output logic [31:0] tl_d_data,
    output logic        tl_d_corrupt,
    output logic        tl_d_valid,
    input  logic        tl_d_ready
);

    localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_a_ready;
    logic              r_d_valid;
    logic [2:0]        r_d_opcode;
    logic [3:0]        r_d_size;
    logic              r_d_denied;
    logic              r_d_corrupt;
    logic              r_data_sel;
    logic [13:0]       r_cnt;
    logic [ADDR_W-1:0] r_rd_idx;

    logic [32:0]       w_span;
    logic              w_inrange;
    logic              w_aligned;
    logic              w_err;
    logic [13:0]       w_beats;
    logic              w_multi;
    logic              w_is_put;
    logic [31:0]       w_a_off;
    logic [ADDR_W-1:0] w_a_idx;
    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_a_fire;
    logic              w_d_fire;
    logic              w_wr_en;
    logic [3:0]        w_wr_be;
    logic [2:0]        w_rsp_opcode;
    logic              w_rsp_denied;
    logic              w_rsp_corrupt;
    logic [31:0]       w_ram_rdata;
    logic              unused_bits;

    // Range check is done in 33 bits so a window ending at 4 GiB still works.
    assign w_span    = 33'd1 << tl_a_size;
    assign w_inrange = ({1'b0, tl_a_address} >= {1'b0, BASE_ADDR}) &&
                       (({1'b0, tl_a_address} + w_span) <= WINDOW_END);
    assign w_aligned = (tl_a_address & (w_span[31:0] - 32'd1)) == 32'd0;
    assign w_err     = !w_inrange || !w_aligned;
    assign w_beats   = beat_count(tl_a_size);
    assign w_multi   = (w_beats != 14'd1);
    assign w_is_put  = (tl_a_opcode == A_PUT_FULL) || (tl_a_opcode == A_PUT_PARTIAL);
    assign w_a_off   = tl_a_address - BASE_ADDR;
    assign w_a_idx   = w_a_off[ADDR_W+1:2];
    assign w_a_fire  = tl_a_valid && r_a_ready;
    assign w_d_fire  = r_d_valid && tl_d_ready;

    assign w_wr_en = w_a_fire && (r_state == ST_IDLE) && w_is_put && !w_multi &&
                     !w_err && WRITE_ENABLE && !tl_a_corrupt && !core_reset_i;
    assign w_wr_be = w_wr_en ? tl_a_mask : 4'b0000;

    assign unused_bits = ^{tl_a_param, w_a_off[31:ADDR_W+2], w_a_off[1:0]};

    always_comb begin
        w_next_state  = r_state;
        w_rsp_opcode  = D_ACCESS_ACK_DATA;
        w_rsp_denied  = 1'b1;
        w_rsp_corrupt = 1'b1;
        w_rd_idx      = r_rd_idx;

        case (tl_a_opcode)
            A_GET: begin
                w_rsp_denied  = w_err;
                w_rsp_corrupt = w_err;
            end
            A_PUT_FULL, A_PUT_PARTIAL: begin
                w_rsp_opcode  = D_ACCESS_ACK;
                w_rsp_denied  = w_err || !WRITE_ENABLE || w_multi;
                w_rsp_corrupt = 1'b0;
            end
            A_INTENT: begin
                w_rsp_opcode  = D_HINT_ACK;
                w_rsp_denied  = 1'b0;
                w_rsp_corrupt = 1'b0;
            end
            default: ;
        endcase

        case (r_state)
            ST_IDLE: begin
                w_rd_idx = w_a_idx;
                if (w_a_fire) begin
                    if (tl_a_opcode == A_GET) begin
                        w_next_state = ST_READ;
                    end else if ((tl_a_opcode == A_INTENT) || !w_multi) begin
                        w_next_state = ST_ACK;
                    end else begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_READ: begin
                // Advance the RAM address only when the current beat is taken.
                if (w_d_fire) begin
                    w_rd_idx = r_rd_idx + 1'b1;
                    if (r_cnt == 14'd1) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_a_fire && (r_cnt == 14'd1)) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_d_fire) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            r_a_ready   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 4'd0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_data_sel  <= 1'b0;
            r_cnt       <= 14'd0;
            r_rd_idx    <= '0;
        end else begin
            r_a_ready <= (w_next_state == ST_IDLE) || (w_next_state == ST_DRAIN);
            r_d_valid <= (w_next_state == ST_READ) || (w_next_state == ST_ACK);
            r_rd_idx  <= w_rd_idx;
            if ((r_state == ST_IDLE) && w_a_fire) begin
                r_d_opcode  <= w_rsp_opcode;
                r_d_size    <= tl_a_size;
                r_d_denied  <= w_rsp_denied;
                r_d_corrupt <= w_rsp_corrupt;
                r_data_sel  <= (tl_a_opcode == A_GET) && !w_err;
                // Gets count D beats; everything else counts remaining A beats.
                r_cnt       <= (tl_a_opcode == A_GET) ? w_beats : (w_beats - 14'd1);
            end else if (((r_state == ST_DRAIN) && w_a_fire) ||
                         ((r_state == ST_READ) && w_d_fire)) begin
                r_cnt <= r_cnt - 14'd1;
            end
        end
    end

    tl_imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk     (core_clock_i),
        .wr_be   (w_wr_be),
        .wr_addr (w_a_idx),
        .wr_data (tl_a_data),
        .rd_addr (w_rd_idx),
        .rd_data (w_ram_rdata)
    );

    assign tl_a_ready   = r_a_ready;
    assign tl_d_valid   = r_d_valid;
    assign tl_d_opcode  = r_d_opcode;
    assign tl_d_param   = 2'b00;
    assign tl_d_size    = r_d_size;
    assign tl_d_denied  = r_d_denied;
    assign tl_d_corrupt = r_d_corrupt;
    assign tl_d_data    = r_data_sel ? w_ram_rdata : 32'd0;

endmodule
`default_nettype wire
